// File: rtl/mbm_mult_arbiter.sv
// Round-robin arbiter feeding a shared combinational mantissa multiplier through a
// two-stage pipeline: S1 holds the granted operands, S2 is the registered result.
module mbm_mult_arbiter #(
   parameter int BIT_WIDTH = 8,
   parameter int NUM_REQ   = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_a,
   input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_b,
   output logic [BIT_WIDTH-1:0]          mul_a,
   output logic [BIT_WIDTH-1:0]          mul_b,
   input  logic [2*BIT_WIDTH-1:0]        mul_product,
   output logic                          resp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    resp_id,
   output logic [2*BIT_WIDTH-1:0]        resp_product,
   input  logic                          resp_ready,
   output logic [CNT_WIDTH-1:0]          ops_count
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int IX_W = ID_W + 1;
   localparam logic [IX_W-1:0]      NUM_REQ_X = IX_W'(NUM_REQ);
   localparam logic [ID_W-1:0]      LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   logic                   s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]        s1_id_q, s1_id_d;
   logic [BIT_WIDTH-1:0]   s1_a_q, s1_a_d;
   logic [BIT_WIDTH-1:0]   s1_b_q, s1_b_d;
   logic                   s2_valid_q, s2_valid_d;
   logic [ID_W-1:0]        s2_id_q, s2_id_d;
   logic [2*BIT_WIDTH-1:0] s2_prod_q, s2_prod_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]   ops_q, ops_d;

   logic                   s2_free_s;
   logic                   s1_adv_s;
   logic                   found_s;
   logic                   accept_s;
   logic [ID_W-1:0]        win_s;
   logic [IX_W-1:0]        idx_s;

   // Round-robin search from rr_ptr upward, wrapping at NUM_REQ (not at a power of two)
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = {1'b0, rr_ptr_q} + IX_W'(k);
         if (idx_s >= NUM_REQ_X) begin
            idx_s = idx_s - NUM_REQ_X;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
            found_s = 1'b1;
            win_s   = idx_s[ID_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign s2_free_s = !s2_valid_q || resp_ready;
   assign s1_adv_s  = !s1_valid_q || s2_free_s;
   assign accept_s  = s1_adv_s && found_s && !rst;

   // Grant vector and next-state for both pipeline stages, pointer and counter
   always_comb begin
      req_ready  = '0;
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_id_d    = s2_id_q;
      s2_prod_d  = s2_prod_q;
      rr_ptr_d   = rr_ptr_q;
      ops_d      = ops_q;

      if (s2_free_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_id_d   = s1_id_q;
            s2_prod_d = mul_product;
         end else begin
            s2_id_d   = s2_id_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end

      if (s1_adv_s) begin
         s1_valid_d = accept_s;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (accept_s) begin
         req_ready[win_s] = 1'b1;
         s1_id_d  = win_s;
         s1_a_d   = req_a[win_s*BIT_WIDTH +: BIT_WIDTH];
         s1_b_d   = req_b[win_s*BIT_WIDTH +: BIT_WIDTH];
         rr_ptr_d = (win_s == LAST_ID) ? '0 : win_s + ID_W'(1);
         ops_d    = (ops_q == CNT_MAX) ? ops_q : ops_q + CNT_WIDTH'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Pipeline, pointer and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
         s2_prod_q  <= '0;
         rr_ptr_q   <= '0;
         ops_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_id_q    <= s2_id_d;
         s2_prod_q  <= s2_prod_d;
         rr_ptr_q   <= rr_ptr_d;
         ops_q      <= ops_d;
      end
   end

   assign mul_a        = s1_a_q;
   assign mul_b        = s1_b_q;
   assign resp_valid   = s2_valid_q;
   assign resp_id      = s2_id_q;
   assign resp_product = s2_prod_q;
   assign ops_count    = ops_q;

endmodule

// File: tb/tb_mbm_mult_arbiter.sv
// Randomized and directed bench for mbm_mult_arbiter against a queue-based
// model of the in-flight operations and a plain-arithmetic round-robin search.
module tb_mbm_mult_arbiter;

   localparam int BW      = 8;
   localparam int NR      = 4;
   localparam int CW      = 4;
   localparam int CNT_MAX = 15;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NR-1:0]       req_valid = '0;
   logic [NR-1:0]       req_ready;
   logic [NR*BW-1:0]    req_a = '0;
   logic [NR*BW-1:0]    req_b = '0;
   logic [BW-1:0]       mul_a, mul_b;
   logic [2*BW-1:0]     mul_product;
   logic                resp_valid;
   logic [1:0]          resp_id;
   logic [2*BW-1:0]     resp_product;
   logic                resp_ready = 1'b1;
   logic [CW-1:0]       ops_count;

   mbm_mult_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
      .resp_ready(resp_ready), .ops_count(ops_count)
   );

   assign mul_product = 16'(mul_a) * 16'(mul_b);

   always #5 clk = ~clk;

   typedef struct {
      int       id;
      int       a;
      int       b;
      bit       at_out;
   } op_t;

   op_t     q[$];
   int      m_rr = 0;
   int      m_ops = 0;
   int      n_checks = 0;
   int      n_errors = 0;
   int      drain_cnt = 0;
   int      acc_cnt = 0;
   logic [NR-1:0] obs_rdy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare outputs with the model at the negedge, then advance the model.
   task automatic step();
      bit   out_v, s1_occ, s2_free, adv, found;
      int   w;
      int   exp_rdy;
      op_t  n;
      @(negedge clk);
      out_v   = (q.size() > 0) && q[0].at_out;
      s1_occ  = (q.size() > 0) && !q[q.size()-1].at_out;
      s2_free = !out_v || resp_ready;
      adv     = !s1_occ || s2_free;
      found   = 1'b0;
      w       = 0;
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (m_rr + k) % NR;
         if (!found && req_valid[i]) begin
            found = 1'b1;
            w     = i;
         end
      end
      exp_rdy = (!rst && adv && found) ? (1 << w) : 0;
      obs_rdy = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("resp_valid", 32'(resp_valid), 32'(out_v));
      if (out_v) begin
         check("resp_id", 32'(resp_id), 32'(q[0].id));
         check("resp_product", 32'(resp_product), 32'(q[0].a * q[0].b));
      end
      if (s1_occ) begin
         check("mul_a", 32'(mul_a), 32'(q[q.size()-1].a));
         check("mul_b", 32'(mul_b), 32'(q[q.size()-1].b));
      end
      check("ops_count", 32'(ops_count), 32'(m_ops));
      if (!rst && resp_valid && resp_ready) drain_cnt++;
      if (req_ready != '0) acc_cnt++;

      if (rst) begin
         q.delete();
         m_rr  = 0;
         m_ops = 0;
      end else begin
         if (s2_free) begin
            if (out_v) void'(q.pop_front());
            if (q.size() > 0) begin
               n = q[0];
               n.at_out = 1'b1;
               q[0] = n;
            end
         end
         if (adv && found) begin
            n.id     = w;
            n.a      = int'(req_a[w*BW +: BW]);
            n.b      = int'(req_b[w*BW +: BW]);
            n.at_out = 1'b0;
            q.push_back(n);
            m_rr = (w + 1) % NR;
            if (m_ops < CNT_MAX) m_ops++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      step();
      step();
      rst       = 1'b0;
      req_valid = 4'h0;
   endtask

   initial begin
      int stall_rdy;

      // Reset state
      do_reset();
      check("rst_product", 32'(resp_product), 32'h0);
      check("rst_id", 32'(resp_id), 32'h0);
      check("rst_mul_a", 32'(mul_a), 32'h0);
      check("rst_ops", 32'(ops_count), 32'h0);

      // Single request from requester 1
      req_a     = {8'h00, 8'h00, 8'hC0, 8'h00};
      req_b     = {8'h00, 8'h00, 8'hA0, 8'h00};
      req_valid = 4'b0010;
      step();
      check("single_grant", 32'(obs_rdy), 32'h2);
      req_valid = 4'b0000;
      step();
      check("single_valid", 32'(resp_valid), 32'h1);
      check("single_id", 32'(resp_id), 32'h1);
      check("single_product", 32'(resp_product), 32'h7800);

      // Fairness with all requesters active
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req_a     = 32'($urandom);
         req_b     = 32'($urandom);
         req_valid = 4'hF;
         step();
         check("fair_grant", 32'(obs_rdy), 32'(1 << (i % 4)));
      end
      check("fair_ops", 32'(ops_count), 32'd8);
      req_valid = 4'h0;
      step();
      step();

      // Backpressure on a requester-0 stream
      do_reset();
      drain_cnt = 0;
      acc_cnt   = 0;
      stall_rdy = 0;
      for (int c = 0; c < 10; c++) begin
         req_a      = 32'($urandom);
         req_b      = 32'($urandom);
         req_valid  = 4'b0001;
         resp_ready = !(c >= 3 && c <= 6);
         step();
         if (c >= 4 && c <= 6 && obs_rdy != '0) stall_rdy++;
      end
      req_valid  = 4'h0;
      resp_ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
      check("bp_stall_ready", 32'(stall_rdy), 32'h0);
      check("bp_drained", 32'(drain_cnt), 32'(acc_cnt));

      // Skip and wrap from rr_ptr = 3
      do_reset();
      req_valid = 4'b0100;
      step();
      req_valid = 4'b0101;
      step();
      check("wrap_first", 32'(obs_rdy), 32'h1);
      step();
      check("wrap_second", 32'(obs_rdy), 32'h4);
      req_valid = 4'h0;
      step();

      // Reset mid-flight
      do_reset();
      req_valid = 4'b0010;
      step();
      req_valid = 4'b1000;
      step();
      rst       = 1'b1;
      req_valid = 4'h0;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("midrst_valid", 32'(resp_valid), 32'h0);
      end
      check("midrst_ops", 32'(ops_count), 32'h0);
      req_valid = 4'b1110;
      step();
      check("midrst_grant", 32'(obs_rdy), 32'h2);

      // Counter saturation
      do_reset();
      req_valid = 4'hF;
      for (int c = 0; c < 20; c++) step();
      check("sat_ops", 32'(ops_count), 32'd15);
      req_valid = 4'h0;
      step();

      // Randomized traffic with occasional reset
      do_reset();
      for (int c = 0; c < 500; c++) begin
         req_a      = 32'($urandom);
         req_b      = 32'($urandom);
         req_valid  = 4'($urandom);
         resp_ready = ($urandom_range(0, 9) < 7);
         rst        = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mbm_mult_arbiter.md
MBM_MULT_ARBITER -- requirements
Module: mbm_mult_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BIT_WIDTH, 8, mantissa width including the leading one.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CNT_WIDTH, 16, width of the issued-operation counter.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-005 req_ready  out  NUM_REQ  per-requester accept; combinational, at most one bit high per cycle.
REQ-006 req_a, req_b  in  NUM_REQ*BIT_WIDTH each  packed operands; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-007 mul_a, mul_b  out  BIT_WIDTH each  operands to the shared combinational approximate mantissa multiplier; driven directly from stage-1 registers.
REQ-008 mul_product  in  2*BIT_WIDTH  combinational product returned by the shared multiplier for mul_a, mul_b.
REQ-009 resp_valid  out  1  result valid.
REQ-010 resp_id  out  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-011 resp_product  out  2*BIT_WIDTH  registered product.
REQ-012 resp_ready  in  1  consumer accepts the result.
REQ-013 ops_count  out  CNT_WIDTH  number of accepted operations; saturating.

Function
REQ-014 Pipeline: S1 holds {valid, id, a, b} and drives mul_a/mul_b. S2 holds {valid, id, product}; S2 is the output register.
REQ-015 Transfer rules, with s2_free = !s2_valid || resp_ready:
- S2 loads from S1 when s2_free; s2_valid next = s1_valid.
- S1 advance = !s1_valid || s2_free.
- An accept occurs when S1 advance is true and any req_valid bit is high.
REQ-016 Latency: an operand pair accepted at edge T is presented as resp_valid at edge T+2 when resp_ready stays high; throughput is one operation per cycle.
REQ-017 Arbitration is round-robin: search req_valid starting at rr_ptr, ascending with wrap; the first set bit wins.
REQ-018 req_ready[g] is high only when g is the winner and an accept occurs.
REQ-019 On an accept, rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds. rr_ptr wraps correctly for non-power-of-two NUM_REQ.
REQ-020 S2 captures mul_product together with the S1 id in the same edge; resp_product and resp_id hold stable while resp_valid && !resp_ready.
REQ-021 When S2 is stalled but S1 is empty, S1 accepts one operation, so two operations are buffered. No further accept occurs until S2 drains.
REQ-022 resp_ready is permitted high while resp_valid is low; this has no effect beyond allowing advance.
REQ-023 ops_count increments by 1 per accept and saturates at 2^CNT_WIDTH-1.
REQ-024 mul_a and mul_b hold their last values when S1 is empty (no gating required); the bench ignores them when S1 is invalid.
REQ-025 A simultaneous accept into S1 and drain from S2 in one cycle is legal and loses no data.

Reset
REQ-026 While rst is high at an edge: s1_valid, s2_valid, rr_ptr, ops_count, resp_id, resp_product and S1 operands clear to 0. req_ready is 0 during the reset cycle.
REQ-027 Reset mid-operation discards all in-flight operations; no resp_valid is produced for them after reset deasserts.
REQ-028 The first accept after reset grants the lowest-index valid requester.

Verification
REQ-029 Single request: NUM_REQ=4, req_valid=0010, a=0xC0, b=0xA0, resp_ready=1, bench multiplier exact. Required: req_ready=0010 in the same cycle; two edges later resp_valid=1, resp_id=1, resp_product=0x7800.
REQ-030 Fairness: all four req_valid held high for 8 cycles, resp_ready=1. Required: grant order 0,1,2,3,0,1,2,3; ops_count=8.
REQ-031 Backpressure: stream from requester 0 with resp_ready=0 from cycle 3 to cycle 6. Required:
- Exactly 2 operations are buffered and req_ready is 0 while stalled.
- resp_product is stable during the stall.
- After release, results appear in order with no loss or duplication.
REQ-032 Skip and wrap: rr_ptr=3, req_valid=0101. Required: grant requester 0, then rr_ptr=1; the next grant is requester 2.
REQ-033 Reset mid-flight: assert rst one cycle after two accepts. Required: resp_valid stays 0 after reset; ops_count=0; the next grant goes to the lowest-index requester.
REQ-034 Saturation: CNT_WIDTH=4, 20 accepts. Required: ops_count stops at 15.
